// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO master that serialises one read/write frame per command.
// Ports: clk_50/reset (sync, active-high); cmd_valid/cmd_ready handshake with cmd_write,
// cmd_phy_addr, cmd_reg_addr, cmd_wdata; rsp_valid pulse with rsp_rdata; busy;
// mdc, mdio_o, mdio_oe drive the PHY pad, mdio_i is the asynchronous pad input.
module mdio_master #(
  parameter int CLK_DIV       = 10,
  parameter int PREAMBLE_BITS = 32
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] WRAP = CW'(2 * CLK_DIV - 1);
  localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_BITS == 0 ? 0 : PREAMBLE_BITS - 1);
  typedef enum logic [3:0] {IDLE, PRE, ST, OP, PHYAD, REGAD, TA, DATA, DONE} state_t;
  state_t st, nst;
  logic [CW-1:0] cnt;
  logic [4:0] idx, nidx, last, phy, regad;
  logic [15:0] wdata, rd_sh;
  logic [1:0] sync;
  logic wr, nbit, noe;
  assign cmd_ready = ~reset & ~busy;
  // Next (field, bit) position and the pad value for that bit, applied at the MDC falling edge.
  always_comb begin
    last = st == PRE ? PRE_LAST : (st == PHYAD || st == REGAD) ? 5'd4 : st == DATA ? 5'd15 : st == DONE ? 5'd0 : 5'd1;
    nidx = idx == last ? 5'd0 : idx + 5'd1;
    nst = idx != last ? st : st == PRE ? ST : st == ST ? OP : st == OP ? PHYAD : st == PHYAD ? REGAD :
          st == REGAD ? TA : st == TA ? DATA : DONE;
    noe = 1'b1;
    nbit = 1'b1;
    case (nst)
      ST:      nbit = nidx[0];
      OP:      nbit = nidx[0] ~^ wr;
      PHYAD:   nbit = phy[3'd4 - nidx[2:0]];
      REGAD:   nbit = regad[3'd4 - nidx[2:0]];
      TA:      begin noe = wr; nbit = ~wr | ~nidx[0]; end
      DATA:    begin noe = wr; nbit = ~wr | wdata[~nidx[3:0]]; end
      DONE:    noe = 1'b0;
      default: ;
    endcase
  end
  always_ff @(posedge clk_50) begin
    sync <= {sync[0], mdio_i};
    rsp_valid <= 1'b0;
    if (reset) begin
      st <= IDLE;
      busy <= 1'b0;
      cnt <= '0;
      idx <= '0;
      mdc <= 1'b0;
      mdio_o <= 1'b1;
      mdio_oe <= 1'b0;
      rsp_rdata <= '0;
    end else if (cmd_valid && cmd_ready) begin
      st <= PREAMBLE_BITS == 0 ? ST : PRE;
      busy <= 1'b1;
      cnt <= '0;
      idx <= '0;
      wr <= cmd_write;
      phy <= cmd_phy_addr;
      regad <= cmd_reg_addr;
      wdata <= cmd_wdata;
      mdc <= 1'b0;
      mdio_o <= PREAMBLE_BITS != 0;
      mdio_oe <= 1'b1;
    end else if (busy) begin
      cnt <= cnt == WRAP ? '0 : cnt + CW'(1);
      if (cnt == HALF) begin
        mdc <= st != DONE;
        if (st == DATA && !wr) rd_sh <= {rd_sh[14:0], sync[1]};
      end
      if (cnt == WRAP) begin
        mdc <= 1'b0;
        if (st == DONE) begin
          st <= IDLE;
          busy <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= wr ? 16'h0 : rd_sh;
        end else begin
          st <= nst;
          idx <= nidx;
          mdio_o <= nbit;
          mdio_oe <= noe;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed scoreboard bench for mdio_master (default and short-frame instances).
module tb_mdio_master;
  localparam int LAT = 1301;
  logic clk_50 = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [4:0] cmd_phy_addr = '0, cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, busy, mdc, mdio_o, mdio_oe, mdio_i;
  logic [15:0] rsp_rdata;
  logic v1 = 1'b0, w1 = 1'b1;
  logic [4:0] pa1 = 5'h0A, ra1 = 5'h15;
  logic [15:0] wd1 = 16'h5A5A;
  logic rdy1, rv1, busy1, mdc1, o1, oe1;
  logic [15:0] rd1;
  int cyc = 0, total = 0, bad = 0, rises = 0;
  logic [1:0] bq[$];
  logic [15:0] rq_data[$];
  int rq_cyc[$];
  logic phy_drv = 1'b1, f_wr = 1'b1, mdc_q = 1'b0;
  logic [15:0] phy_val = '0, f_rd = '0;

  mdio_master dut (
    .clk_50(clk_50), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
  );

  mdio_master #(.CLK_DIV(4), .PREAMBLE_BITS(0)) u1 (
    .clk_50(clk_50), .reset(reset), .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_write(w1), .cmd_phy_addr(pa1), .cmd_reg_addr(ra1),
    .cmd_wdata(wd1), .rsp_valid(rv1), .rsp_rdata(rd1), .busy(busy1),
    .mdc(mdc1), .mdio_o(o1), .mdio_oe(oe1), .mdio_i(1'b1)
  );

  assign mdio_i = mdio_oe ? mdio_o : phy_drv;
  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // PHY model and scoreboard: frame bits checked at each MDC rise, responses on rsp_valid.
  always @(negedge clk_50) begin : mon
    logic [1:0] e;
    if (reset) begin
      rises = 0;
      phy_drv = 1'b1;
    end else begin
      if (cmd_valid && cmd_ready) begin
        rises = 0;
        f_wr = cmd_write;
        f_rd = phy_val;
      end
      if (mdc && !mdc_q) begin
        rises++;
        chk("bit_pending", 32'(bq.size() != 0), 1);
        if (bq.size() != 0) begin
          e = bq.pop_front();
          chk("mdio_oe", 32'(mdio_oe), 32'(e[1]));
          if (e[1]) chk("mdio_o", 32'(mdio_o), 32'(e[0]));
        end
        phy_drv = (!f_wr && rises >= 48 && rises <= 63) ? f_rd[63 - rises] : 1'b1;
      end
      if (rsp_valid) begin
        chk("rsp_pending", 32'(rq_data.size() != 0), 1);
        if (rq_data.size() != 0) begin
          chk("rsp_rdata", 32'(rsp_rdata), 32'(rq_data.pop_front()));
          chk("rsp_latency", cyc, rq_cyc.pop_front());
          chk("rsp_idle_oe", 32'(mdio_oe), 0);
          chk("rsp_ready", 32'(cmd_ready), 1);
        end
      end
    end
    mdc_q = mdc;
  end

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic issue(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic [15:0] rd, input logic hold, output int k);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_phy_addr = pa;
    cmd_reg_addr = ra;
    cmd_wdata = wd;
    phy_val = rd;
    while (!cmd_ready && n < 3000) begin
      tick();
      n++;
    end
    chk("accept", 32'(cmd_ready), 1);
    k = cyc;
    if (cmd_ready) begin
      for (int i = 0; i < 32; i++) bq.push_back(2'b11);
      bq.push_back(2'b10);
      bq.push_back(2'b11);
      bq.push_back(w ? 2'b10 : 2'b11);
      bq.push_back(w ? 2'b11 : 2'b10);
      for (int i = 4; i >= 0; i--) bq.push_back({1'b1, pa[i]});
      for (int i = 4; i >= 0; i--) bq.push_back({1'b1, ra[i]});
      bq.push_back(w ? 2'b11 : 2'b00);
      bq.push_back(w ? 2'b10 : 2'b00);
      for (int i = 15; i >= 0; i--) bq.push_back(w ? {1'b1, wd[i]} : 2'b00);
      rq_data.push_back(w ? 16'h0 : rd);
      rq_cyc.push_back(k + LAT);
    end
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rq_data.size() != 0 && n < 5000) begin
      tick();
      n++;
    end
    chk("rsp_done", 32'(rq_data.size()), 0);
  endtask

  initial begin
    int k, k2, n, lat, nr;
    logic [3:0] fb;
    logic m1q;
    repeat (3) tick();
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mdc", 32'(mdc), 0);
    chk("rst_mdio_o", 32'(mdio_o), 1);
    chk("rst_mdio_oe", 32'(mdio_oe), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 1);
    tick();
    issue(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0, 1'b0, k);
    chk("busy_after_accept", 32'(busy), 1);
    chk("ready_after_accept", 32'(cmd_ready), 0);
    wait_idle();
    chk("hold_wr_rdata", 32'(rsp_rdata), 0);
    issue(1'b0, 5'h01, 5'h02, 16'hFFFF, 16'h0141, 1'b0, k);
    wait_idle();
    chk("hold_rd_rdata", 32'(rsp_rdata), 32'h0141);
    issue(1'b1, 5'h03, 5'h04, 16'hA5C3, 16'h0, 1'b1, k);
    issue(1'b0, 5'h05, 5'h1F, 16'h0, 16'hBEEF, 1'b0, k2);
    chk("b2b_gap", k2 - k, LAT);
    wait_idle();
    issue(1'b1, 5'h07, 5'h11, 16'h0F0F, 16'h0, 1'b0, k);
    repeat (200) tick();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_phy_addr = 5'h1E;
    cmd_reg_addr = 5'h01;
    chk("mid_busy", 32'(busy), 1);
    chk("mid_ready", 32'(cmd_ready), 0);
    repeat (3) tick();
    cmd_valid = 1'b0;
    wait_idle();
    repeat (60) tick();
    issue(1'b1, 5'h02, 5'h1B, 16'hCAFE, 16'h0, 1'b0, k);
    n = 0;
    while (rises < 43 && n < 3000) begin
      tick();
      n++;
    end
    chk("reach_regad", 32'(rises >= 43), 1);
    reset = 1'b1;
    bq.delete();
    rq_data.delete();
    rq_cyc.delete();
    tick();
    chk("abort_mdc", 32'(mdc), 0);
    chk("abort_oe", 32'(mdio_oe), 0);
    chk("abort_ready", 32'(cmd_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rsp", 32'(rsp_valid), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_ready_rel", 32'(cmd_ready), 1);
    tick();
    issue(1'b0, 5'h1F, 5'h10, 16'h0, 16'h8001, 1'b0, k);
    wait_idle();
    chk("abort_read_rdata", 32'(rsp_rdata), 32'h8001);
    chk("u1_ready", 32'(rdy1), 1);
    v1 = 1'b1;
    k = cyc;
    tick();
    v1 = 1'b0;
    lat = 0;
    nr = 0;
    fb = '0;
    m1q = 1'b0;
    for (int i = 0; i < 400 && lat == 0; i++) begin
      if (mdc1 && !m1q) begin
        if (nr < 4) fb = {fb[2:0], o1};
        nr++;
      end
      m1q = mdc1;
      if (rv1) lat = cyc - k;
      tick();
    end
    chk("u1_latency", lat, 265);
    chk("u1_rises", nr, 32);
    chk("u1_first_bits", 32'(fb), 32'b0101);
    chk("u1_rdata", 32'(rd1), 0);
    chk("bits_left", 32'(bq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
